// File: rtl/teclado_pkg.sv
// Shared types and helpers for the 4x4 membrane keypad scanner.
// Holds the scan FSM state encoding, the matrix geometry and a one-hot test.
package teclado_pkg;

  localparam int FILAS    = 4;
  localparam int COLUMNAS = 4;

  typedef enum logic [1:0] {
    SCAN,
    DEB_PRESS,
    PRESSED,
    DEB_RELEASE
  } estado_barrido_t;

  // True only for exactly one active bit; zero or several keys in a row read as "no key".
  function automatic logic es_onehot(input logic [3:0] v);
    return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
  endfunction

endpackage

// File: rtl/sincronizador_columnas.sv
// Two-flop synchronizer for asynchronous keypad lines, with a configurable
// reset value so idle (pulled-up) lines start out inactive.
module sincronizador_columnas #(
  parameter int                 WIDTH     = 4,
  parameter logic [WIDTH-1:0]   RESET_VAL = '1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // NOTE: reset is synchronous, so it only appears inside the clocked branch;
  // every register here uses <= so both stages update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/barrido_teclado.sv
// Row scanner and debouncer for a 4x4 membrane keypad: drives one row low per
// dwell, samples the columns at the end of it and reports accepted presses/releases.
module barrido_teclado
  import teclado_pkg::*;
#(
  parameter int SCAN_TICKS  = 1000,
  parameter int DEB_SAMPLES = 4
) (
  input  logic                clk,
  input  logic                reset,
  output logic [FILAS-1:0]    fila_drv,
  input  logic [COLUMNAS-1:0] columna_pin,
  output logic [FILAS-1:0]    fila,
  output logic [COLUMNAS-1:0] columna,
  output logic                tecla_valida,
  output logic                tecla_soltada,
  output logic                tecla_presionada
);

  localparam int TW = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
  localparam int CW = $clog2(DEB_SAMPLES + 1);

  localparam logic [TW-1:0] TICK_LAST = TW'(SCAN_TICKS - 1);
  localparam logic [CW-1:0] DEB_LAST  = CW'(DEB_SAMPLES - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  generate
    if (SCAN_TICKS < 4) begin : g_bad_scan_ticks
      $error("barrido_teclado: SCAN_TICKS must be at least 4");
    end
    if (DEB_SAMPLES < 2) begin : g_bad_deb_samples
      $error("barrido_teclado: DEB_SAMPLES must be at least 2");
    end
  endgenerate

  logic [COLUMNAS-1:0] col_sync;
  logic [COLUMNAS-1:0] col_act;

  sincronizador_columnas #(
    .WIDTH     (COLUMNAS),
    .RESET_VAL ({COLUMNAS{1'b1}})
  ) u_sincronizador (
    .clk   (clk),
    .reset (reset),
    .d_i   (columna_pin),
    .q_o   (col_sync)
  );

  assign col_act = ~col_sync;

  // Dwell timer: free-running, so the sample instant stays periodic while frozen.
  logic [TW-1:0] timer_q;
  logic [TW-1:0] timer_d;
  logic          muestra;

  always_comb begin
    muestra = (timer_q == TICK_LAST);
    timer_d = muestra ? '0 : timer_q + TW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) timer_q <= '0;
    else       timer_q <= timer_d;
  end

  estado_barrido_t     estado_q;
  logic [CW-1:0]       cnt_q;
  logic [FILAS-1:0]    fila_drv_q;
  logic [FILAS-1:0]    cand_fila_q;
  logic [COLUMNAS-1:0] cand_col_q;
  logic [FILAS-1:0]    fila_q;
  logic [COLUMNAS-1:0] columna_q;
  logic                valida_q;
  logic                soltada_q;
  logic                presionada_q;

  logic                sample_single;
  logic                sample_vacio;
  logic                sample_igual;
  logic [FILAS-1:0]    fila_siguiente;

  always_comb begin
    sample_single  = es_onehot(col_act);
    sample_vacio   = (col_act == '0);
    sample_igual   = (col_act == cand_col_q);
    fila_siguiente = {fila_drv_q[FILAS-2:0], fila_drv_q[FILAS-1]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      estado_q     <= SCAN;
      cnt_q        <= '0;
      fila_drv_q   <= 4'b1110;
      cand_fila_q  <= '0;
      cand_col_q   <= '0;
      fila_q       <= '0;
      columna_q    <= '0;
      valida_q     <= 1'b0;
      soltada_q    <= 1'b0;
      presionada_q <= 1'b0;
    end else begin
      valida_q  <= 1'b0;
      soltada_q <= 1'b0;
      if (muestra) begin
        unique case (estado_q)
          SCAN: begin
            if (sample_single) begin
              cand_fila_q <= ~fila_drv_q;
              cand_col_q  <= col_act;
              cnt_q       <= CNT_ONE;
              estado_q    <= DEB_PRESS;
            end else begin
              fila_drv_q  <= fila_siguiente;
            end
          end

          DEB_PRESS: begin
            if (!sample_igual) begin
              cnt_q      <= '0;
              fila_drv_q <= fila_siguiente;
              estado_q   <= SCAN;
            end else if (cnt_q == DEB_LAST) begin
              cnt_q        <= cnt_q + CNT_ONE;
              fila_q       <= cand_fila_q;
              columna_q    <= cand_col_q;
              valida_q     <= 1'b1;
              presionada_q <= 1'b1;
              estado_q     <= PRESSED;
            end else begin
              cnt_q <= cnt_q + CNT_ONE;
            end
          end

          PRESSED: begin
            if (sample_vacio) begin
              cnt_q    <= CNT_ONE;
              estado_q <= DEB_RELEASE;
            end
          end

          DEB_RELEASE: begin
            // Any column coming back means the key is still held; no release pulse.
            if (!sample_vacio) begin
              cnt_q    <= '0;
              estado_q <= PRESSED;
            end else if (cnt_q == DEB_LAST) begin
              cnt_q        <= '0;
              soltada_q    <= 1'b1;
              presionada_q <= 1'b0;
              fila_drv_q   <= fila_siguiente;
              estado_q     <= SCAN;
            end else begin
              cnt_q <= cnt_q + CNT_ONE;
            end
          end

          default: begin
            cnt_q    <= '0;
            estado_q <= SCAN;
          end
        endcase
      end
    end
  end

  assign fila_drv         = fila_drv_q;
  assign fila             = fila_q;
  assign columna          = columna_q;
  assign tecla_valida     = valida_q;
  assign tecla_soltada    = soltada_q;
  assign tecla_presionada = presionada_q;

endmodule
